// File: rtl/win_lose_detector.sv
// ---------------------------------------------------------------------------
// win_lose_detector
//
// Watches the game counter value and qualifies arrival at the win terminal
// value (and, optionally, the lose terminal value). When the target has been
// seen on HOLD_CYCLES consecutive valid samples, it emits a one-cycle
// registered winner (or loser) pulse. After a pulse the detector locks out
// until the count leaves the scored value. gameover (from flag_counter.flag)
// freezes detection and disarms the detector. The detector re-arms only after
// the count is seen away from every target. This keeps the counter's reset
// value from producing a spurious result.
//
// Optional feature macro: LOSER_DETECT_EN
//   defined     : LOSE_VALUE comparison, LOSE_QUAL state and loser pulse exist
//   not defined : loser tied to 0; IDLE arms on any sample != WIN_VALUE
//
// Parameters
//   WIDTH        width of the game counter value
//   WIN_VALUE    count value that scores a win
//   LOSE_VALUE   count value that scores a loss (LOSER_DETECT_EN only)
//   HOLD_CYCLES  consecutive valid target samples required, legal 1..15
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   count        game counter value
//   count_valid  count is sampled only on edges where this is 1
//   gameover     1 = return to IDLE and stay there (synchronous)
//   winner       one-cycle win pulse (to flag_counter.trigger)
//   loser        one-cycle lose pulse
//   armed        1 while in ARMED, WIN_QUAL or LOSE_QUAL
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module win_lose_detector #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] WIN_VALUE   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] LOSE_VALUE  = '0,
    parameter int unsigned      HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             count_valid,
    input  logic             gameover,
    output logic             winner,
    output logic             loser,
    output logic             armed
);

    localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WIN_QUAL,
        S_LOSE_QUAL,
        S_LOCKOUT
    } state_e;

    typedef enum logic [1:0] {
        HIT_NONE,
        HIT_WIN,
        HIT_LOSE
    } hit_e;

    state_e           state_q, state_d;
    logic [3:0]       qual_q, qual_d;
    logic [WIDTH-1:0] lock_q, lock_d;      // target value that was just scored
    logic             winner_q, winner_d;
    logic             armed_q, armed_d;

    logic             hit_win;
    logic             hit_lose_raw;        // equals LOSE_VALUE, ignoring win priority
    logic             hit_lose;
    hit_e             hit;
    logic             evaluate;
    logic [3:0]       prior;
    logic [3:0]       run_len;

`ifdef LOSER_DETECT_EN
    logic             loser_q, loser_d;
`else
    logic             unused_lose;
    assign unused_lose = ^LOSE_VALUE;
`endif

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        qual_d   = qual_q;
        lock_d   = lock_q;
        winner_d = 1'b0;                   // pulses clear on every edge
`ifdef LOSER_DETECT_EN
        loser_d  = 1'b0;
`endif
        evaluate = 1'b0;
        prior    = '0;
        run_len  = '0;

        hit_win = (count == WIN_VALUE);
`ifdef LOSER_DETECT_EN
        hit_lose_raw = (count == LOSE_VALUE);
`else
        hit_lose_raw = 1'b0;
`endif
        // Win takes priority when both targets share a value.
        hit_lose = hit_lose_raw && !hit_win;
        hit      = hit_win ? HIT_WIN : (hit_lose ? HIT_LOSE : HIT_NONE);

        if (gameover) begin
            state_d = S_IDLE;
            qual_d  = '0;
        end else if (count_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (!hit_win && !hit_lose_raw) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    evaluate = 1'b1;
                end
                S_WIN_QUAL: begin
                    evaluate = 1'b1;
                    if (hit == HIT_WIN) begin
                        prior = qual_q;
                    end
                end
`ifdef LOSER_DETECT_EN
                S_LOSE_QUAL: begin
                    evaluate = 1'b1;
                    if (hit == HIT_LOSE) begin
                        prior = qual_q;
                    end
                end
`endif
                S_LOCKOUT: begin
                    // Hold while the scored target persists; the first
                    // differing sample is judged exactly as ARMED would.
                    evaluate = (count != lock_q);
                end
                default: begin
                    state_d = S_IDLE;
                    qual_d  = '0;
                end
            endcase

            // Common evaluation: extend the current run or start a new one.
            // prior < HOLD <= 15, so the increment cannot wrap.
            if (evaluate) begin
                run_len = prior + 4'd1;
                if (hit == HIT_NONE) begin
                    state_d = S_ARMED;
                    qual_d  = '0;
                end else if (run_len >= HOLD) begin
                    state_d = S_LOCKOUT;
                    qual_d  = HOLD;        // saturate
                    lock_d  = count;
`ifdef LOSER_DETECT_EN
                    if (hit == HIT_WIN) begin
                        winner_d = 1'b1;
                    end else begin
                        loser_d  = 1'b1;
                    end
`else
                    winner_d = 1'b1;
`endif
                end else begin
`ifdef LOSER_DETECT_EN
                    state_d = (hit == HIT_WIN) ? S_WIN_QUAL : S_LOSE_QUAL;
`else
                    state_d = S_WIN_QUAL;
`endif
                    qual_d  = run_len;
                end
            end
        end

        armed_d = (state_d == S_ARMED) || (state_d == S_WIN_QUAL) ||
                  (state_d == S_LOSE_QUAL);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            qual_q   <= '0;
            lock_q   <= '0;
            winner_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            qual_q   <= qual_d;
            lock_q   <= lock_d;
            winner_q <= winner_d;
            armed_q  <= armed_d;
        end
    end

`ifdef LOSER_DETECT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loser_q <= 1'b0;
        end else begin
            loser_q <= loser_d;
        end
    end

    assign loser = loser_q;
`else
    assign loser = 1'b0;
`endif

    assign winner = winner_q;
    assign armed  = armed_q;

endmodule

// File: tb/tb_win_lose_detector.sv
// ---------------------------------------------------------------------------
// tb_win_lose_detector
//
// Directed bench for win_lose_detector (WIDTH=4, HOLD_CYCLES=2). A run-length
// model tracks, since the last arming, the value of the latest valid sample
// and how many consecutive valid samples carried it. A pulse is due when a
// target's run length reaches HOLD. The detector is armed when it is not idle
// and not sitting on a target run that already scored. Outputs are compared
// against the model on every falling edge; literal expectations after
// selected edges pin the model. Honours LOSER_DETECT_EN like the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_win_lose_detector;

    localparam logic [3:0] WIN  = 4'hF;
    localparam logic [3:0] LOSE = 4'h0;
    localparam int         HOLD = 2;

    logic       clk;
    logic       rst;
    logic [3:0] count;
    logic       count_valid;
    logic       gameover;
    logic       winner;
    logic       loser;
    logic       armed;

    int n_checks = 0;
    int n_fail   = 0;

    win_lose_detector #(
        .WIDTH      (4),
        .WIN_VALUE  (WIN),
        .LOSE_VALUE (LOSE),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .count_valid(count_valid),
        .gameover   (gameover),
        .winner     (winner),
        .loser      (loser),
        .armed      (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Run-length model
    // ------------------------------------------------------------------
    function automatic bit is_win(input logic [3:0] v);
        return v == WIN;
    endfunction

    function automatic bit is_lose(input logic [3:0] v);
`ifdef LOSER_DETECT_EN
        return (v == LOSE) && (v != WIN);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_target(input logic [3:0] v);
        return is_win(v) || is_lose(v);
    endfunction

    logic       m_idle;
    logic [3:0] m_last;
    int         m_run;
    logic       exp_winner;
    logic       exp_loser;
    logic       exp_armed;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idle     <= 1'b1;
            m_last     <= '0;
            m_run      <= 0;
            exp_winner <= 1'b0;
            exp_loser  <= 1'b0;
            exp_armed  <= 1'b0;
        end else begin
            automatic int run_n = 1;
            exp_winner <= 1'b0;
            exp_loser  <= 1'b0;
            if (gameover) begin
                m_idle    <= 1'b1;
                m_run     <= 0;
                exp_armed <= 1'b0;
            end else if (count_valid) begin
                if (m_idle) begin
                    if (!is_target(count)) begin
                        m_idle    <= 1'b0;
                        m_last    <= count;
                        m_run     <= 1;
                        exp_armed <= 1'b1;
                    end
                end else begin
                    run_n = (count == m_last) ? m_run + 1 : 1;
                    if (run_n > 100) run_n = 100;
                    m_last     <= count;
                    m_run      <= run_n;
                    exp_winner <= (run_n == HOLD) && is_win(count);
                    exp_loser  <= (run_n == HOLD) && is_lose(count);
                    exp_armed  <= !(is_target(count) && run_n >= HOLD);
                end
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        check("winner", {31'd0, winner}, {31'd0, exp_winner});
        check("loser",  {31'd0, loser},  {31'd0, exp_loser});
        check("armed",  {31'd0, armed},  {31'd0, exp_armed});
        check("exclusive", {31'd0, winner & loser}, 32'd0);
    end

    // One edge of stimulus; returns 1 ns after the rising edge.
    task automatic step(input logic [3:0] c, input logic v, input logic go);
        @(negedge clk);
        count       = c;
        count_valid = v;
        gameover    = go;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        count       = 4'h0;
        count_valid = 1'b0;
        gameover    = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset winner", {31'd0, winner}, 32'd0);
        check("reset loser",  {31'd0, loser},  32'd0);
        check("reset armed",  {31'd0, armed},  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 1: count at the reset value must not arm (lose target), 5 arms.
        for (int i = 0; i < 4; i++) begin
            step(4'h0, 1'b1, 1'b0);
`ifdef LOSER_DETECT_EN
            check("t1 armed on 0", {31'd0, armed}, 32'd0);
`else
            check("t1 armed on 0", {31'd0, armed}, 32'd1);
`endif
            check("t1 loser", {31'd0, loser}, 32'd0);
        end
        step(4'h5, 1'b1, 1'b0);
        check("t1 armed on 5", {31'd0, armed}, 32'd1);

        // 2: two wins, lockout in between.
        step(WIN, 1'b1, 1'b0);
        check("t2 first 15", {31'd0, winner}, 32'd0);
        step(WIN, 1'b1, 1'b0);
        check("t2 pulse", {31'd0, winner}, 32'd1);
        check("t2 lockout armed", {31'd0, armed}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(WIN, 1'b1, 1'b0);
            check("t2 held 15", {31'd0, winner}, 32'd0);
        end
        step(4'h3, 1'b1, 1'b0);
        check("t2 rearm", {31'd0, armed}, 32'd1);
        step(WIN, 1'b1, 1'b0);
        step(WIN, 1'b1, 1'b0);
        check("t2 second pulse", {31'd0, winner}, 32'd1);

        // 3: broken runs do not score; invalid gaps are ignored.
        step(4'h3, 1'b1, 1'b0);
        check("t3 pulse cleared", {31'd0, winner}, 32'd0);
        step(WIN, 1'b1, 1'b0);
        step(4'h7, 1'b1, 1'b0);
        step(WIN, 1'b1, 1'b0);
        step(4'h7, 1'b1, 1'b0);
        check("t3 broken run", {31'd0, winner}, 32'd0);
        step(WIN, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'h9, 1'b0, 1'b0);
            check("t3 gap", {31'd0, winner}, 32'd0);
        end
        step(WIN, 1'b1, 1'b0);
        check("t3 pulse across gap", {31'd0, winner}, 32'd1);
        step(4'h9, 1'b0, 1'b0);
        check("t3 clear on invalid edge", {31'd0, winner}, 32'd0);

        // 4: gameover overrides a due pulse and requires re-arming.
        step(4'h6, 1'b1, 1'b0);
        check("t4 armed", {31'd0, armed}, 32'd1);
        step(WIN, 1'b1, 1'b0);
        step(WIN, 1'b1, 1'b1);
        check("t4 gameover winner", {31'd0, winner}, 32'd0);
        check("t4 gameover armed",  {31'd0, armed},  32'd0);
        step(4'h6, 1'b1, 1'b1);
        check("t4 held idle", {31'd0, armed}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(WIN, 1'b1, 1'b0);
            check("t4 no pulse unarmed", {31'd0, winner}, 32'd0);
        end
        step(4'h6, 1'b1, 1'b0);
        check("t4 rearmed", {31'd0, armed}, 32'd1);
        step(WIN, 1'b1, 1'b0);
        step(WIN, 1'b1, 1'b0);
        check("t4 pulse after rearm", {31'd0, winner}, 32'd1);

        // 5: asynchronous reset mid-cycle.
        step(4'h3, 1'b1, 1'b0);
        step(WIN, 1'b1, 1'b0);
        step(WIN, 1'b1, 1'b0);
        check("t5 pulse", {31'd0, winner}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5 async winner", {31'd0, winner}, 32'd0);
        check("t5 async armed",  {31'd0, armed},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(4'h3, 1'b1, 1'b0);
        check("t5 armed", {31'd0, armed}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5 async armed drop", {31'd0, armed}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 6: lose path, switching between targets.
        step(4'h3, 1'b1, 1'b0);
        step(LOSE, 1'b1, 1'b0);
        step(LOSE, 1'b1, 1'b0);
`ifdef LOSER_DETECT_EN
        check("t6 loser pulse", {31'd0, loser}, 32'd1);
`else
        check("t6 loser pulse", {31'd0, loser}, 32'd0);
`endif
        check("t6 no winner", {31'd0, winner}, 32'd0);
        step(WIN, 1'b1, 1'b0);
        check("t6 loser cleared", {31'd0, loser}, 32'd0);
        step(WIN, 1'b1, 1'b0);
        check("t6 winner after lose", {31'd0, winner}, 32'd1);
        step(4'h3, 1'b1, 1'b0);
        step(WIN, 1'b1, 1'b0);
        step(LOSE, 1'b1, 1'b0);
        step(LOSE, 1'b1, 1'b0);
`ifdef LOSER_DETECT_EN
        check("t6 win->lose switch", {31'd0, loser}, 32'd1);
`else
        check("t6 win->lose switch", {31'd0, loser}, 32'd0);
`endif
        check("t6 switch no winner", {31'd0, winner}, 32'd0);
        step(LOSE, 1'b1, 1'b0);
        check("t6 lose lockout", {31'd0, loser}, 32'd0);

        repeat (3) step(4'h4, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
